jtag_axi_master_fsm: RTL and testbench
======================================

# jtag_axi_master_fsm

AXI-clock-domain master engine that sits directly downstream of the JTAG TAP data registers, on the read side of the request async FIFO. It pops one transaction descriptor per request (address, write data, size, strobe, direction) and issues a single-beat AXI4 read or write. It then pushes a status word into the status async FIFO, which returns it to the TAP side. A per-transaction watchdog reports hung slaves without violating the AXI protocol.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (32 or 64)
- TIMEOUT_CYCLES, 4096, watchdog limit in clk_axi cycles, ≥2
- TXN_ID, 0, constant AWID/ARID value

Ports (one clock; reset is synchronous and active-low):
- clk_axi  in  1  AXI clock; all logic on its rising edge
- ares_axi  in  1  synchronous active-low reset
- req_valid  in  1  request FIFO not empty
- req_ready  out  1  pop request FIFO
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  transaction address
- req_wdata  in  DATA_WIDTH  write data
- req_size  in  3  AXI size code
- req_wstrb  in  DATA_WIDTH/8  write strobes
- sts_valid  out  1  push status FIFO
- sts_ready  in  1  status FIFO not full
- sts_rdata  out  DATA_WIDTH  read data (0 for writes)
- sts_code  out  3  0 OKAY, 1 EXOKAY, 2 SLVERR, 3 DECERR, 4 TIMEOUT
- m_awvalid/m_awready/m_awaddr/m_awsize/m_awid/m_awlen/m_awburst  AXI AW channel (awlen=0, awburst=INCR)
- m_wvalid/m_wready/m_wdata/m_wstrb/m_wlast  AXI W channel (wlast=1)
- m_bvalid/m_bready/m_bresp  AXI B channel
- m_arvalid/m_arready/m_araddr/m_arsize/m_arid/m_arlen/m_arburst  AXI AR channel (arlen=0)
- m_rvalid/m_rready/m_rdata/m_rresp/m_rlast  AXI R channel

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, STATUS, DRAIN.
- IDLE: req_ready=1. On req_valid, latch the descriptor and go to WR_REQ or RD_REQ. The pop and latch happen in the same cycle.
- WR_REQ: assert awvalid and wvalid together. Each drops independently after its own handshake (flags aw_done, w_done). Go to WR_RESP once both are done, including the case where both complete in the same cycle.
- WR_RESP: bready=1. On the B handshake, capture bresp into sts_code, clear rdata, go to STATUS.
- RD_REQ: arvalid=1 until arready, then go to RD_RESP.
- RD_RESP: rready=1. On the R handshake, capture rdata and rresp, go to STATUS.
- STATUS: sts_valid=1 until sts_ready, then go to IDLE. sts_* outputs are registered and stable while sts_valid is high.
- Watchdog:
  - Counter clears on leaving IDLE and increments every cycle in WR_REQ, WR_RESP, RD_REQ, RD_RESP.
  - When the count reaches TIMEOUT_CYCLES-1, set sts_code=4 and rdata=0, and go to STATUS.
  - Any valid already asserted stays high until its handshake completes; AXI forbids withdrawing it.
  - After the status push, enter DRAIN instead of IDLE.
- DRAIN:
  - Finishes any outstanding AW/W/AR handshakes.
  - Holds bready/rready=1 and discards the response.
  - Returns to IDLE only once the response is consumed.
  - req_ready=0 throughout; it may remain here indefinitely.
- AXI outputs are driven only from registers (no combinational ready→valid paths). m_*prot=0.

## Timing
- Reset (ares_axi=0 at a clock edge):
  - State returns to IDLE.
  - All valids, req_ready, sts_valid, bready and rready are 0; sts_rdata=0, sts_code=0, counter=0.
  - req_ready rises 1 cycle after reset deasserts.
- Reset mid-transaction abandons the transaction. The system resets the interconnect together with this block.
- Best-case latency: req pop at cycle 0 → awvalid/wvalid (or arvalid) at cycle 1.
  - With zero-wait slave responses, sts_valid rises at cycle 3.
  - With sts_ready=1, the next req_ready rises at cycle 4.
- The block has only one transaction in flight; it never pipelines.
- A response arriving in the same cycle as timeout expiry: the response wins and is reported normally.
- sts_ready low: sts_valid is held and no new request is popped.

## Test plan
- Write addr 0x1000, data 0xDEADBEEF, wstrb 0xF, slave OKAY with zero wait → one AW and one W beat with correct fields; status push with code 0 and rdata 0; the next req_ready arrives 4 cycles after the pop.
- Read addr 0x2004, slave returns 0xCAFEF00D with SLVERR → status rdata 0xCAFEF00D, code 2.
- Write where awready arrives 3 cycles before wready → awvalid drops after its handshake, wvalid stays high until its own handshake, exactly one of each, then a normal B.
- TIMEOUT_CYCLES=16, slave never asserts arready → status code 4 pushed 16 cycles after arvalid rises; arvalid stays high; req_ready stays 0 until arready and rvalid finally arrive, then returns to IDLE.
- sts_ready held low for 10 cycles after a read → sts_valid and its data are stable for all 10 cycles; no req pop happens before the status handshake.
- ares_axi pulsed low during WR_RESP → next cycle all outputs are at reset values and state is IDLE; a subsequent request completes normally.

Source files
------------

// File: rtl/jtag_axi_master_fsm.sv
// Single-beat AXI4 master driven by JTAG request descriptors; each transaction
// ends with one status word, and a watchdog reports hung slaves as TIMEOUT.
module jtag_axi_master_fsm #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TXN_ID         = 0,
    parameter int ID_WIDTH       = 4
) (
    input  logic                      clk_axi,
    input  logic                      ares_axi,
    // request FIFO read side
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [2:0]                req_size,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    // status FIFO write side
    output logic                      sts_valid,
    input  logic                      sts_ready,
    output logic [DATA_WIDTH-1:0]     sts_rdata,
    output logic [2:0]                sts_code,
    // AXI AW
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [2:0]                m_awsize,
    output logic [ID_WIDTH-1:0]       m_awid,
    output logic [7:0]                m_awlen,
    output logic [1:0]                m_awburst,
    output logic [2:0]                m_awprot,
    // AXI W
    output logic                      m_wvalid,
    input  logic                      m_wready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wlast,
    // AXI B
    input  logic                      m_bvalid,
    output logic                      m_bready,
    input  logic [1:0]                m_bresp,
    // AXI AR
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [ADDR_WIDTH-1:0]     m_araddr,
    output logic [2:0]                m_arsize,
    output logic [ID_WIDTH-1:0]       m_arid,
    output logic [7:0]                m_arlen,
    output logic [1:0]                m_arburst,
    output logic [2:0]                m_arprot,
    // AXI R
    input  logic                      m_rvalid,
    output logic                      m_rready,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rlast,
    // observability
    output logic [2:0]                o_dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [2:0] CODE_TIMEOUT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_STATUS  = 3'd5,
        S_DRAIN   = 3'd6
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic                      r_req_ready;
    logic                      r_is_write;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [2:0]                r_size;
    logic [DATA_WIDTH/8-1:0]   r_wstrb;

    logic                      r_awvalid;
    logic                      r_wvalid;
    logic                      r_arvalid;
    logic                      r_bready;
    logic                      r_rready;
    logic                      r_aw_done;
    logic                      r_w_done;

    logic [CNT_W-1:0]          r_wdog;
    logic                      r_timed_out;

    logic                      r_sts_valid;
    logic [2:0]                r_sts_code;
    logic [DATA_WIDTH-1:0]     r_sts_rdata;

    logic                      w_pop;
    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_b_hs;
    logic                      w_ar_hs;
    logic                      w_r_hs;
    logic                      w_wr_done;
    logic                      w_timeout;
    logic                      w_load_sts;
    logic                      w_set_timeout;
    logic [2:0]                w_sts_code_nxt;
    logic [DATA_WIDTH-1:0]     w_sts_rdata_nxt;

    // Every channel transfers on a cycle where its valid and ready are both
    // high at the rising edge; a valid, once raised, holds until that edge.
    assign w_pop     = r_req_ready & req_valid;
    assign w_aw_hs   = r_awvalid & m_awready;
    assign w_w_hs    = r_wvalid & m_wready;
    assign w_b_hs    = r_bready & m_bvalid;
    assign w_ar_hs   = r_arvalid & m_arready;
    assign w_r_hs    = r_rready & m_rvalid;
    assign w_wr_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
    assign w_timeout = (r_wdog >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_axi) begin
        if (!ares_axi) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_load_sts      = 1'b0;
        w_set_timeout   = 1'b0;
        w_sts_code_nxt  = r_sts_code;
        w_sts_rdata_nxt = r_sts_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = req_write ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                if (w_wr_done) begin
                    w_state_nxt = S_WR_RESP;
                end else if (w_timeout) begin
                    w_state_nxt     = S_STATUS;
                    w_load_sts      = 1'b1;
                    w_set_timeout   = 1'b1;
                    w_sts_code_nxt  = CODE_TIMEOUT;
                    w_sts_rdata_nxt = '0;
                end
            end
            S_WR_RESP: begin
                // a response landing on the expiry cycle is reported normally
                if (w_b_hs) begin
                    w_state_nxt     = S_STATUS;
                    w_load_sts      = 1'b1;
                    w_sts_code_nxt  = {1'b0, m_bresp};
                    w_sts_rdata_nxt = '0;
                end else if (w_timeout) begin
                    w_state_nxt     = S_STATUS;
                    w_load_sts      = 1'b1;
                    w_set_timeout   = 1'b1;
                    w_sts_code_nxt  = CODE_TIMEOUT;
                    w_sts_rdata_nxt = '0;
                end
            end
            S_RD_REQ: begin
                if (w_ar_hs) begin
                    w_state_nxt = S_RD_RESP;
                end else if (w_timeout) begin
                    w_state_nxt     = S_STATUS;
                    w_load_sts      = 1'b1;
                    w_set_timeout   = 1'b1;
                    w_sts_code_nxt  = CODE_TIMEOUT;
                    w_sts_rdata_nxt = '0;
                end
            end
            S_RD_RESP: begin
                if (w_r_hs) begin
                    w_state_nxt     = S_STATUS;
                    w_load_sts      = 1'b1;
                    w_sts_code_nxt  = {1'b0, m_rresp};
                    w_sts_rdata_nxt = m_rdata;
                end else if (w_timeout) begin
                    w_state_nxt     = S_STATUS;
                    w_load_sts      = 1'b1;
                    w_set_timeout   = 1'b1;
                    w_sts_code_nxt  = CODE_TIMEOUT;
                    w_sts_rdata_nxt = '0;
                end
            end
            S_STATUS: begin
                if (sts_ready) begin
                    w_state_nxt = r_timed_out ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                // the abandoned response is swallowed before any new request
                if (r_is_write ? w_b_hs : (w_r_hs & m_rlast)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_axi) begin
        if (!ares_axi) begin
            r_req_ready <= 1'b0;
            r_is_write  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_wdog      <= '0;
            r_timed_out <= 1'b0;
            r_sts_valid <= 1'b0;
            r_sts_code  <= '0;
            r_sts_rdata <= '0;
        end else begin
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_bready    <= (w_state_nxt == S_WR_RESP) ||
                           ((w_state_nxt == S_DRAIN) && r_is_write);
            r_rready    <= (w_state_nxt == S_RD_RESP) ||
                           ((w_state_nxt == S_DRAIN) && !r_is_write);
            r_sts_valid <= (w_state_nxt == S_STATUS);

            // request valids outlive a timeout: they fall only on their handshake
            if (w_aw_hs) begin
                r_awvalid <= 1'b0;
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_wvalid <= 1'b0;
                r_w_done <= 1'b1;
            end
            if (w_ar_hs) begin
                r_arvalid <= 1'b0;
            end

            if ((r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                (r_state == S_RD_REQ) || (r_state == S_RD_RESP)) begin
                if (!w_timeout) begin
                    r_wdog <= r_wdog + CNT_W'(1);
                end
            end

            if (w_load_sts) begin
                r_sts_code  <= w_sts_code_nxt;
                r_sts_rdata <= w_sts_rdata_nxt;
            end
            if (w_set_timeout) begin
                r_timed_out <= 1'b1;
            end

            if (w_pop) begin
                r_is_write  <= req_write;
                r_addr      <= req_addr;
                r_wdata     <= req_wdata;
                r_size      <= req_size;
                r_wstrb     <= req_wstrb;
                r_awvalid   <= req_write;
                r_wvalid    <= req_write;
                r_arvalid   <= !req_write;
                r_aw_done   <= 1'b0;
                r_w_done    <= 1'b0;
                r_wdog      <= '0;
                r_timed_out <= 1'b0;
            end
        end
    end

    assign req_ready   = r_req_ready;
    assign sts_valid   = r_sts_valid;
    assign sts_code    = r_sts_code;
    assign sts_rdata   = r_sts_rdata;

    assign m_awvalid   = r_awvalid;
    assign m_awaddr    = r_addr;
    assign m_awsize    = r_size;
    assign m_awid      = ID_WIDTH'(TXN_ID);
    assign m_awlen     = 8'd0;
    assign m_awburst   = 2'b01;
    assign m_awprot    = 3'd0;

    assign m_wvalid    = r_wvalid;
    assign m_wdata     = r_wdata;
    assign m_wstrb     = r_wstrb;
    assign m_wlast     = 1'b1;

    assign m_bready    = r_bready;

    assign m_arvalid   = r_arvalid;
    assign m_araddr    = r_addr;
    assign m_arsize    = r_size;
    assign m_arid      = ID_WIDTH'(TXN_ID);
    assign m_arlen     = 8'd0;
    assign m_arburst   = 2'b01;
    assign m_arprot    = 3'd0;

    assign m_rready    = r_rready;

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_jtag_axi_master_fsm.sv
// Directed bench for jtag_axi_master_fsm: an AXI slave model with per-channel
// delay knobs, and a status scoreboard fed by the stimulus and drained by a monitor.
module tb_jtag_axi_master_fsm;

    localparam int TB_ID = 5;
    localparam int SW    = 35;  // {code[2:0], rdata[31:0]}

    logic        clk_axi = 1'b0;
    logic        ares_axi;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic [3:0]  req_wstrb;
    logic        sts_valid, sts_ready;
    logic [31:0] sts_rdata;
    logic [2:0]  sts_code;
    logic        m_awvalid, m_awready;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awsize, m_awprot;
    logic [3:0]  m_awid;
    logic [7:0]  m_awlen;
    logic [1:0]  m_awburst;
    logic        m_wvalid, m_wready, m_wlast;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_bvalid, m_bready;
    logic [1:0]  m_bresp;
    logic        m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic [2:0]  m_arsize, m_arprot;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [1:0]  m_arburst;
    logic        m_rvalid, m_rready, m_rlast;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic [2:0]  o_dbg_state;

    jtag_axi_master_fsm #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16), .TXN_ID(TB_ID), .ID_WIDTH(4)
    ) dut (
        .clk_axi(clk_axi), .ares_axi(ares_axi),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_wstrb(req_wstrb),
        .sts_valid(sts_valid), .sts_ready(sts_ready), .sts_rdata(sts_rdata), .sts_code(sts_code),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awsize(m_awsize),
        .m_awid(m_awid), .m_awlen(m_awlen), .m_awburst(m_awburst), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arsize(m_arsize),
        .m_arid(m_arid), .m_arlen(m_arlen), .m_arburst(m_arburst), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_axi = ~clk_axi;

    int cyc = 0;
    always @(posedge clk_axi) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [SW-1:0] exp_q[$];

    logic [31:0] exp_addr  = '0;
    logic [31:0] exp_wdata = '0;
    logic [3:0]  exp_wstrb = '0;
    logic [2:0]  exp_size  = '0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;

    // slave knobs
    int          cfg_aw_delay = 0;
    int          cfg_w_delay  = 0;
    logic        cfg_ar_block = 1'b0;
    logic        cfg_b_block  = 1'b0;
    logic [1:0]  cfg_bresp    = 2'b00;
    logic [1:0]  cfg_rresp    = 2'b00;
    logic [31:0] cfg_rdata    = '0;

    // handshakes as seen at the negedge preceding each rising edge
    logic aw_hs = 1'b0, w_hs = 1'b0, b_hs = 1'b0, ar_hs = 1'b0, r_hs = 1'b0;
    logic rst_seen = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event did not occur within bound (cycle %0d)", name, cyc);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_axi) begin
        logic [SW-1:0] e;
        aw_hs    = m_awvalid & m_awready;
        w_hs     = m_wvalid & m_wready;
        b_hs     = m_bvalid & m_bready;
        ar_hs    = m_arvalid & m_arready;
        r_hs     = m_rvalid & m_rready;
        rst_seen = !ares_axi;
        if (ares_axi) begin
            if (aw_hs) begin
                aw_cnt++;
                check("awaddr", m_awaddr, exp_addr);
                check("aw_fields", {m_awid, m_awsize, m_awlen, m_awburst, m_awprot},
                      {4'(TB_ID), exp_size, 8'd0, 2'b01, 3'd0});
            end
            if (w_hs) begin
                w_cnt++;
                check("wdata", m_wdata, exp_wdata);
                check("wstrb_wlast", {m_wstrb, m_wlast}, {exp_wstrb, 1'b1});
            end
            if (ar_hs) begin
                ar_cnt++;
                check("araddr", m_araddr, exp_addr);
                check("ar_fields", {m_arid, m_arsize, m_arlen, m_arburst, m_arprot},
                      {4'(TB_ID), exp_size, 8'd0, 2'b01, 3'd0});
            end
            if (sts_valid && sts_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sts_unexpected: got code %0d rdata 0x%0h, required no push",
                             sts_code, sts_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("sts_code", sts_code, e[34:32]);
                    check("sts_rdata", sts_rdata, e[31:0]);
                end
            end
        end
    end

    // ---------------- AXI slave model ----------------
    initial begin
        int   aw_wait, w_wait;
        logic aw_got, w_got, ar_got;
        aw_wait = 0; w_wait = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_bresp = 0;
        m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;
        forever begin
            @(posedge clk_axi);
            #1;
            if (rst_seen) begin
                aw_wait = 0; w_wait = 0;
                aw_got = 0; w_got = 0; ar_got = 0;
                m_awready = 0; m_wready = 0; m_arready = 0;
                m_bvalid = 0; m_rvalid = 0; m_rlast = 0;
            end else begin
                if (b_hs) m_bvalid = 0;
                if (r_hs) begin m_rvalid = 0; m_rlast = 0; end
                if (aw_hs) aw_got = 1;
                if (w_hs)  w_got = 1;
                if (ar_hs) ar_got = 1;
                if (aw_got && w_got && !cfg_b_block && !m_bvalid) begin
                    m_bvalid = 1; m_bresp = cfg_bresp; aw_got = 0; w_got = 0;
                end
                if (ar_got && !m_rvalid) begin
                    m_rvalid = 1; m_rdata = cfg_rdata; m_rresp = cfg_rresp; m_rlast = 1; ar_got = 0;
                end
                m_awready = 0;
                if (m_awvalid) begin
                    if (aw_wait >= cfg_aw_delay) begin m_awready = 1; aw_wait = 0; end
                    else aw_wait++;
                end
                m_wready = 0;
                if (m_wvalid) begin
                    if (w_wait >= cfg_w_delay) begin m_wready = 1; w_wait = 0; end
                    else w_wait++;
                end
                m_arready = m_arvalid && !cfg_ar_block;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] size, input logic [3:0] strb, output int pc);
        @(posedge clk_axi);
        #1;
        req_write = wr; req_addr = addr; req_wdata = data; req_size = size; req_wstrb = strb;
        req_valid = 1'b1;
        pc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_axi);
            if (req_ready) begin pc = cyc; break; end
        end
        if (pc < 0) fail_bound("req_pop");
        @(posedge clk_axi);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_sts(output int c);
        c = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_axi);
            if (sts_valid) begin c = cyc; break; end
        end
        if (c < 0) fail_bound("sts_valid");
    endtask

    task automatic wait_req_ready(output int c);
        c = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_axi);
            if (req_ready) begin c = cyc; break; end
        end
        if (c < 0) fail_bound("req_ready");
    endtask

    task automatic set_exp(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                           input logic [3:0] st);
        exp_addr = a; exp_wdata = d; exp_size = s; exp_wstrb = st;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pc, c, c2, ar_rise, s, a0, w0, r0;
        ares_axi = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_size = '0; req_wstrb = '0; sts_ready = 1'b1;
        repeat (3) @(posedge clk_axi);
        @(negedge clk_axi);
        check("reset_outputs", {req_ready, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                                sts_valid, sts_code, sts_rdata, o_dbg_state}, 64'd0);
        @(posedge clk_axi);
        #1;
        ares_axi = 1'b1;
        @(negedge clk_axi);
        check("req_ready_first_cycle", req_ready, 1'b0);
        @(negedge clk_axi);
        check("req_ready_after_reset", req_ready, 1'b1);

        // zero-wait write, OKAY
        set_exp(32'h1000, 32'hDEADBEEF, 3'd2, 4'hF);
        cfg_bresp = 2'b00;
        a0 = aw_cnt; w0 = w_cnt;
        exp_q.push_back({3'd0, 32'h0});
        send_req(1'b1, 32'h1000, 32'hDEADBEEF, 3'd2, 4'hF, pc);
        wait_sts(c);
        check("wr_sts_latency", c - pc, 3);
        wait_req_ready(c2);
        check("wr_next_req_ready", c2 - pc, 4);
        check("wr_beats", {aw_cnt - a0, w_cnt - w0}, {32'd1, 32'd1});

        // read with SLVERR
        set_exp(32'h2004, 32'h0, 3'd2, 4'h0);
        cfg_rdata = 32'hCAFEF00D; cfg_rresp = 2'b10;
        r0 = ar_cnt;
        exp_q.push_back({3'd2, 32'hCAFEF00D});
        send_req(1'b0, 32'h2004, 32'h0, 3'd2, 4'h0, pc);
        wait_sts(c);
        check("rd_sts_latency", c - pc, 3);
        wait_req_ready(c2);
        check("rd_beats", ar_cnt - r0, 1);

        // write with W accepted 3 cycles after AW, EXOKAY
        set_exp(32'h3008, 32'h0BADF00D, 3'd1, 4'h3);
        cfg_aw_delay = 0; cfg_w_delay = 3; cfg_bresp = 2'b01;
        a0 = aw_cnt; w0 = w_cnt;
        exp_q.push_back({3'd1, 32'h0});
        send_req(1'b1, 32'h3008, 32'h0BADF00D, 3'd1, 4'h3, pc);
        @(negedge clk_axi);
        check("skew_c1_valids", {m_awvalid, m_wvalid}, 2'b11);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk_axi);
            check("skew_w_only", {m_awvalid, m_wvalid}, 2'b01);
        end
        wait_req_ready(c2);
        check("skew_beats", {aw_cnt - a0, w_cnt - w0}, {32'd1, 32'd1});
        cfg_w_delay = 0;

        // read timeout: AR never accepted until released
        set_exp(32'h4000, 32'h0, 3'd2, 4'h0);
        cfg_ar_block = 1'b1; cfg_rdata = 32'h55AA55AA; cfg_rresp = 2'b00;
        exp_q.push_back({3'd4, 32'h0});
        send_req(1'b0, 32'h4000, 32'h0, 3'd2, 4'h0, pc);
        @(negedge clk_axi);
        ar_rise = cyc;
        check("to_arvalid_rise", m_arvalid, 1'b1);
        wait_sts(c);
        check("to_sts_latency", c - ar_rise, 16);
        check("to_arvalid_held", m_arvalid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_axi);
            check("to_drain_hold", {req_ready, m_arvalid, m_rready, o_dbg_state},
                  {1'b0, 1'b1, 1'b1, 3'd6});
        end
        cfg_ar_block = 1'b0;
        wait_req_ready(c2);
        check("to_drain_exit_state", o_dbg_state, 3'd0);

        // status back-pressure for 10 cycles
        set_exp(32'h5000, 32'h0, 3'd2, 4'h0);
        cfg_rdata = 32'h12345678; cfg_rresp = 2'b00;
        sts_ready = 1'b0;
        exp_q.push_back({3'd0, 32'h12345678});
        send_req(1'b0, 32'h5000, 32'h0, 3'd2, 4'h0, pc);
        wait_sts(c);
        set_exp(32'h6000, 32'hA5A5A5A5, 3'd2, 4'hF);
        req_write = 1'b1; req_addr = 32'h6000; req_wdata = 32'hA5A5A5A5;
        req_size = 3'd2; req_wstrb = 4'hF; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_axi);
            check("bp_stable", {req_ready, sts_valid, sts_code, sts_rdata},
                  {1'b0, 1'b1, 3'd0, 32'h12345678});
        end
        @(posedge clk_axi);
        #1;
        sts_ready = 1'b1;
        cfg_bresp = 2'b00;
        exp_q.push_back({3'd0, 32'h0});
        @(negedge clk_axi);
        s = cyc;
        pc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_axi);
            if (req_ready) begin pc = cyc; break; end
        end
        check("bp_pop_after_sts", pc - s, 1);
        @(posedge clk_axi);
        #1;
        req_valid = 1'b0;
        wait_req_ready(c2);

        // reset pulse while waiting for B
        set_exp(32'h7000, 32'h11223344, 3'd2, 4'hF);
        cfg_b_block = 1'b1;
        send_req(1'b1, 32'h7000, 32'h11223344, 3'd2, 4'hF, pc);
        @(negedge clk_axi);
        @(negedge clk_axi);
        check("rst_in_wr_resp", {o_dbg_state, m_bready}, {3'd2, 1'b1});
        @(posedge clk_axi);
        #1;
        ares_axi = 1'b0;
        @(posedge clk_axi);
        #1;
        ares_axi = 1'b1;
        cfg_b_block = 1'b0;
        @(negedge clk_axi);
        check("rst_mid_outputs", {req_ready, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                                  sts_valid, sts_code, sts_rdata, o_dbg_state}, 64'd0);
        @(negedge clk_axi);
        check("rst_mid_req_ready", req_ready, 1'b1);
        set_exp(32'h8000, 32'h55667788, 3'd2, 4'hF);
        exp_q.push_back({3'd0, 32'h0});
        send_req(1'b1, 32'h8000, 32'h55667788, 3'd2, 4'hF, pc);
        wait_sts(c);
        check("post_rst_latency", c - pc, 3);
        wait_req_ready(c2);

        repeat (3) @(negedge clk_axi);
        check("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

endmodule
